mips_cpu_next_pc: RTL and testbench



---
 rtl/mips_cpu_pkg.sv | 15 +
 rtl/mips_cpu_next_pc_if.sv | 32 +++
 rtl/mips_cpu_next_pc.sv | 113 +++++++++++
 tb/tb_mips_cpu_next_pc.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the MIPS CPU next-PC logic.
package mips_cpu_pkg;

  typedef logic [31:0] addr_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DELAY = 2'd1,
    HALT  = 2'd2
  } npc_state_t;

  localparam addr_t RESET_VECTOR = 32'hBFC00000;
  localparam addr_t HALT_ADDR    = 32'h00000000;

endpackage

// File: rtl/mips_cpu_next_pc_if.sv
// Bundle between the pipeline (decode/execute + PC register) and the next-PC stage.
// Redirect strobes (jump, branch_taken) carry no handshake: they are sampled only in a
// cycle where clk_enable & instr_done are high, and the stage never back-pressures.
interface mips_cpu_next_pc_if;
  import mips_cpu_pkg::*;

  logic       clk_enable;
  logic       instr_done;
  addr_t      pc;
  logic       branch_taken;
  addr_t      branch_target;
  logic       jump;
  addr_t      jump_target;

  addr_t      new_pc;
  logic       delay_slot;
  logic       active;
  logic       halted;
  logic       address_error;
  npc_state_t state;

  modport master (
    output clk_enable, instr_done, pc, branch_taken, branch_target, jump, jump_target,
    input  new_pc, delay_slot, active, halted, address_error, state
  );

  modport slave (
    input  clk_enable, instr_done, pc, branch_taken, branch_target, jump, jump_target,
    output new_pc, delay_slot, active, halted, address_error, state
  );

endinterface

// File: rtl/mips_cpu_next_pc.sv
// Next-PC stage: sequential increment, delayed-branch redirect, halt on jump to
// HALT_ADDR and sticky misaligned-target error.
module mips_cpu_next_pc #(
  parameter logic [31:0] RESET_VECTOR = mips_cpu_pkg::RESET_VECTOR,
  parameter logic [31:0] HALT_ADDR    = mips_cpu_pkg::HALT_ADDR
) (
  input  logic              clk,
  input  logic              reset,
  mips_cpu_next_pc_if.slave bus
);
  import mips_cpu_pkg::*;

  npc_state_t state_q, state_d;
  addr_t      target_q, target_d;
  logic       delay_slot_q, delay_slot_d;
  logic       active_q, active_d;
  logic       halted_q, halted_d;
  logic       addr_err_q, addr_err_d;

  logic       adv;
  logic       redirect;
  addr_t      redirect_target;
  addr_t      pc_plus4;
  addr_t      new_pc;

  // Nothing advances unless an instruction retires while the CPU is running.
  assign adv             = bus.clk_enable & bus.instr_done & active_q;
  assign redirect        = bus.jump | bus.branch_taken;
  assign redirect_target = bus.jump ? bus.jump_target : bus.branch_target;
  assign pc_plus4        = bus.pc + 32'd4;

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    delay_slot_d = delay_slot_q;
    active_d     = active_q;
    halted_d     = halted_q;
    addr_err_d   = addr_err_q;
    new_pc       = bus.pc;

    case (state_q)
      RUN: begin
        new_pc = pc_plus4;
        if (adv) begin
          delay_slot_d = 1'b0;
          if (redirect) begin
            if (redirect_target[1:0] != 2'b00) begin
              // Misaligned target stops the CPU before any delay slot runs.
              addr_err_d = 1'b1;
              state_d    = HALT;
              active_d   = 1'b0;
              halted_d   = 1'b1;
            end else begin
              target_d     = redirect_target;
              state_d      = DELAY;
              delay_slot_d = 1'b1;
            end
          end
        end
      end
      DELAY: begin
        new_pc = target_q;
        if (adv) begin
          delay_slot_d = 1'b0;
          if (target_q == HALT_ADDR) begin
            state_d  = HALT;
            active_d = 1'b0;
            halted_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      HALT: begin
        new_pc = bus.pc;
      end
      default: begin
        new_pc = bus.pc;
      end
    endcase

    if (!reset) begin
      new_pc = RESET_VECTOR;
    end
  end

  // With adv low the next-state logic already holds every register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= RUN;
      target_q     <= '0;
      delay_slot_q <= 1'b0;
      active_q     <= 1'b1;
      halted_q     <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      delay_slot_q <= delay_slot_d;
      active_q     <= active_d;
      halted_q     <= halted_d;
      addr_err_q   <= addr_err_d;
    end
  end

  assign bus.new_pc        = new_pc;
  assign bus.delay_slot    = delay_slot_q;
  assign bus.active        = active_q;
  assign bus.halted        = halted_q;
  assign bus.address_error = addr_err_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_mips_cpu_next_pc.sv
// Self-checking bench for mips_cpu_next_pc: directed vector table, a hand-written
// halt-by-branch sequence, then random stimulus against a pending-redirect queue model.
module tb_mips_cpu_next_pc;
  import mips_cpu_pkg::*;

  localparam addr_t RV = 32'hBFC00000;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mips_cpu_next_pc_if bus ();

  mips_cpu_next_pc dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- bookkeeping ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit r, input bit en, input bit done, input addr_t p,
                       input bit j, input addr_t jt, input bit b, input addr_t bt);
    rst_n             = r;
    bus.clk_enable    = en;
    bus.instr_done    = done;
    bus.pc            = p;
    bus.jump          = j;
    bus.jump_target   = jt;
    bus.branch_taken  = b;
    bus.branch_target = bt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_regs(input string tag, input bit ds, input bit act, input bit hlt,
                          input bit err, input npc_state_t st);
    chk({tag, ".delay_slot"}, {31'd0, bus.delay_slot}, {31'd0, ds});
    chk({tag, ".active"}, {31'd0, bus.active}, {31'd0, act});
    chk({tag, ".halted"}, {31'd0, bus.halted}, {31'd0, hlt});
    chk({tag, ".address_error"}, {31'd0, bus.address_error}, {31'd0, err});
    chk({tag, ".state"}, {30'd0, bus.state}, {30'd0, st});
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         r, en, done;
    addr_t      pc;
    bit         j;
    addr_t      jt;
    bit         b;
    addr_t      bt;
    addr_t      exp_npc;
    bit         exp_ds, exp_act, exp_hlt, exp_err;
    npc_state_t exp_st;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit en, bit done, addr_t pc, bit j, addr_t jt,
                              bit b, addr_t bt, addr_t npc, bit ds, bit act, bit hlt,
                              bit err, npc_state_t st);
    vec_t v;
    v.r = r; v.en = en; v.done = done; v.pc = pc; v.j = j; v.jt = jt; v.b = b; v.bt = bt;
    v.exp_npc = npc; v.exp_ds = ds; v.exp_act = act; v.exp_hlt = hlt; v.exp_err = err;
    v.exp_st = st;
    return v;
  endfunction

  // ---------------- reference model ----------------
  // Redirects waiting for their delay slot to retire; the head is where the PC goes next.
  addr_t m_pend[$];
  bit    m_ds, m_act, m_hlt, m_err;

  function automatic addr_t m_new_pc(bit r, addr_t p);
    if (!r) return RV;
    if (m_hlt) return p;
    if (m_pend.size() != 0) return m_pend[0];
    return p + 32'd4;
  endfunction

  function automatic npc_state_t m_state();
    if (m_hlt) return HALT;
    if (m_pend.size() != 0) return DELAY;
    return RUN;
  endfunction

  function automatic void m_edge(bit r, bit en, bit done, bit j, addr_t jt, bit b, addr_t bt);
    addr_t t;
    if (!r) begin
      m_pend.delete();
      m_ds = 0; m_act = 1; m_hlt = 0; m_err = 0;
    end else if (en && done && m_act) begin
      if (m_pend.size() != 0) begin
        t = m_pend.pop_front();
        m_ds = 0;
        if (t == 32'd0) begin m_act = 0; m_hlt = 1; end
      end else if (j || b) begin
        t = j ? jt : bt;
        if ((t % 4) != 0) begin
          m_err = 1; m_hlt = 1; m_act = 0; m_ds = 0;
        end else begin
          m_pend.push_back(t);
          m_ds = 1;
        end
      end else begin
        m_ds = 0;
      end
    end
  endfunction

  function automatic addr_t rand_tgt();
    int sel;
    sel = $urandom_range(0, 31);
    if (sel == 0) return 32'd0;
    if (sel == 1) return ($urandom() & 32'hFFFFFFFC) | addr_t'($urandom_range(1, 3));
    return $urandom() & 32'hFFFFFFFC;
  endfunction

  // ---------------- test ----------------
  initial begin
    vec_t  v;
    bit    r, en, done, j, b;
    addr_t p, jt, bt, exp_npc;

    drive(0, 1, 1, 32'd0, 0, 32'd0, 0, 32'd0);

    vecs.push_back(mk(0,1,1,32'h00000000, 0,32'h0,   0,32'h0,        RV,           0,1,0,0,RUN));
    vecs.push_back(mk(1,1,1,32'hBFC00000, 0,32'h0,   0,32'h0,        32'hBFC00004, 0,1,0,0,RUN));
    vecs.push_back(mk(1,1,1,32'hBFC00010, 0,32'h0,   1,32'hBFC00100, 32'hBFC00014, 1,1,0,0,DELAY));
    vecs.push_back(mk(1,1,1,32'hBFC00014, 0,32'h0,   0,32'h0,        32'hBFC00100, 0,1,0,0,RUN));
    vecs.push_back(mk(1,1,1,32'hBFC00100, 0,32'h0,   0,32'h0,        32'hBFC00104, 0,1,0,0,RUN));
    vecs.push_back(mk(1,1,1,32'hBFC00104, 1,32'h200, 1,32'h300,      32'hBFC00108, 1,1,0,0,DELAY));
    vecs.push_back(mk(1,1,1,32'hBFC00108, 0,32'h0,   1,32'h400,      32'h00000200, 0,1,0,0,RUN));
    vecs.push_back(mk(1,1,1,32'h00000200, 0,32'h0,   0,32'h0,        32'h00000204, 0,1,0,0,RUN));
    vecs.push_back(mk(1,1,1,32'hFFFFFFFC, 0,32'h0,   0,32'h0,        32'h00000000, 0,1,0,0,RUN));
    vecs.push_back(mk(1,1,1,32'h00000000, 0,32'h0,   0,32'h0,        32'h00000004, 0,1,0,0,RUN));
    vecs.push_back(mk(1,1,1,32'h00000004, 0,32'h0,   1,32'hBFC00102, 32'h00000008, 0,0,1,1,HALT));
    vecs.push_back(mk(1,1,1,32'h00000008, 1,32'h100, 0,32'h0,        32'h00000008, 0,0,1,1,HALT));
    vecs.push_back(mk(0,1,1,32'h00000008, 0,32'h0,   0,32'h0,        RV,           0,1,0,0,RUN));
    vecs.push_back(mk(1,1,1,32'hBFC00000, 1,32'h0,   0,32'h0,        32'hBFC00004, 1,1,0,0,DELAY));
    vecs.push_back(mk(1,0,1,32'hBFC00004, 0,32'h0,   0,32'h0,        32'h00000000, 1,1,0,0,DELAY));
    vecs.push_back(mk(1,0,1,32'hBFC00004, 0,32'h0,   0,32'h0,        32'h00000000, 1,1,0,0,DELAY));
    vecs.push_back(mk(1,0,1,32'hBFC00004, 0,32'h0,   0,32'h0,        32'h00000000, 1,1,0,0,DELAY));
    vecs.push_back(mk(1,1,0,32'hBFC00004, 0,32'h0,   0,32'h0,        32'h00000000, 1,1,0,0,DELAY));
    vecs.push_back(mk(1,1,1,32'hBFC00004, 0,32'h0,   0,32'h0,        32'h00000000, 0,0,1,0,HALT));
    vecs.push_back(mk(1,1,1,32'h00000000, 1,32'h40,  0,32'h0,        32'h00000000, 0,0,1,0,HALT));
    vecs.push_back(mk(1,1,1,32'h00000010, 0,32'h0,   1,32'h80,       32'h00000010, 0,0,1,0,HALT));
    vecs.push_back(mk(0,1,0,32'h00000010, 0,32'h0,   0,32'h0,        RV,           0,1,0,0,RUN));
    vecs.push_back(mk(1,1,1,32'hBFC00000, 0,32'h0,   1,32'hBFC00200, 32'hBFC00004, 1,1,0,0,DELAY));
    vecs.push_back(mk(1,0,1,32'hBFC00004, 0,32'h0,   0,32'h0,        32'hBFC00200, 1,1,0,0,DELAY));
    vecs.push_back(mk(1,0,1,32'hBFC00004, 0,32'h0,   0,32'h0,        32'hBFC00200, 1,1,0,0,DELAY));
    vecs.push_back(mk(1,0,1,32'hBFC00004, 0,32'h0,   0,32'h0,        32'hBFC00200, 1,1,0,0,DELAY));
    vecs.push_back(mk(0,0,1,32'hBFC00004, 0,32'h0,   0,32'h0,        RV,           0,1,0,0,RUN));
    vecs.push_back(mk(1,1,1,32'hBFC00000, 0,32'h0,   0,32'h0,        32'hBFC00004, 0,1,0,0,RUN));
    vecs.push_back(mk(1,1,1,32'hBFC00004, 1,32'h201, 1,32'h300,      32'hBFC00008, 0,0,1,1,HALT));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.r, v.en, v.done, v.pc, v.j, v.jt, v.b, v.bt);
      #1;
      chk($sformatf("vec%0d.new_pc", i), bus.new_pc, v.exp_npc);
      tick();
      chk_regs($sformatf("vec%0d", i), v.exp_ds, v.exp_act, v.exp_hlt, v.exp_err, v.exp_st);
    end

    // Hand sequence: taken branch to address 0 with stalls inside its delay slot.
    drive(0, 1, 1, RV, 0, 32'h0, 0, 32'h0);
    tick();
    drive(1, 1, 1, 32'h00000100, 0, 32'h0, 1, 32'h0);
    tick();
    chk_regs("seq_br0.branch", 1, 1, 0, 0, DELAY);
    drive(1, 1, 0, 32'h00000104, 0, 32'h0, 0, 32'h0);
    tick();
    drive(1, 0, 1, 32'h00000104, 0, 32'h0, 0, 32'h0);
    #1;
    chk("seq_br0.stalled_new_pc", bus.new_pc, 32'h0);
    tick();
    chk_regs("seq_br0.stalled", 1, 1, 0, 0, DELAY);
    drive(1, 1, 1, 32'h00000104, 0, 32'h0, 0, 32'h0);
    #1;
    chk("seq_br0.slot_new_pc", bus.new_pc, 32'h0);
    tick();
    chk_regs("seq_br0.halted", 0, 0, 1, 0, HALT);

    // Random phase against the queue model.
    drive(0, 1, 1, RV, 0, 32'h0, 0, 32'h0);
    m_edge(0, 1, 1, 0, 32'h0, 0, 32'h0);
    tick();
    p = RV;
    for (int c = 0; c < 3000; c++) begin
      r    = m_hlt ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 49) != 0);
      en   = ($urandom_range(0, 9) < 8);
      done = ($urandom_range(0, 9) < 7);
      j    = ($urandom_range(0, 9) == 0);
      b    = ($urandom_range(0, 6) == 0);
      jt   = rand_tgt();
      bt   = rand_tgt();
      if ($urandom_range(0, 7) == 0) p = $urandom() & 32'hFFFFFFFC;
      drive(r, en, done, p, j, jt, b, bt);
      #1;
      exp_npc = m_new_pc(r, p);
      chk($sformatf("rnd%0d.new_pc", c), bus.new_pc, exp_npc);
      if (en && done && r) p = exp_npc;
      m_edge(r, en, done, j, jt, b, bt);
      tick();
      chk_regs($sformatf("rnd%0d", c), m_ds, m_act, m_hlt, m_err, m_state());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
